// File: rtl/divider_4_restoring_pkg.sv
// divider_4_restoring_pkg
// Shared definitions for the restoring divider: the FSM state encoding and
// the width of the iteration counter.
//   state_t     : IDLE / RUN / FIN encoding used by the top-level FSM
//   cnt_width() : counter width needed to count WIDTH-1 down to 0
//   CNT_W       : counter width for the default 4-bit divider
package divider_4_restoring_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // The counter starts at WIDTH-1, so clog2(WIDTH) bits are enough.
  // A floor of 1 keeps the counter a legal vector for tiny widths.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/divider_4_restoring_div_step.sv
// divider_4_restoring_div_step
// One restoring-division iteration: trial-subtract the divisor from the
// shifted partial remainder and keep the difference only if it did not
// go negative.
//   rem_in  [WIDTH:0]   : shifted partial remainder R'
//   divisor [WIDTH-1:0] : unsigned divisor
//   rem_out [WIDTH-1:0] : next partial remainder (always < divisor)
//   q_bit               : quotient bit produced by this iteration
module divider_4_restoring_div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic           borrow;

  // R' is always below twice the divisor, so the MSB of the WIDTH+1-bit
  // difference acts as the borrow-out: set exactly when R' < divisor.
  // In both outcomes the kept value is below the divisor, so its top bit
  // is zero and only WIDTH bits need to be carried forward.
  always_comb begin
    trial   = rem_in - {1'b0, divisor};
    borrow  = trial[WIDTH];
    q_bit   = ~borrow;
    rem_out = borrow ? rem_in[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/divider_4_restoring.sv
// divider_4_restoring
// Sequential unsigned restoring divider, one quotient bit per clock, MSB
// first. A start pulse latches the operands; WIDTH clocks later done
// pulses for one cycle with quotient and remainder. A zero divisor skips
// the iterations and reports all-ones / dividend with div_by_zero set.
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset
//   start       : request a division (ignored while busy)
//   dividend    : unsigned dividend, sampled with start
//   divisor     : unsigned divisor, sampled with start
//   busy        : high while iterations are in progress
//   done        : one-cycle pulse, results valid from this cycle
//   quotient    : result, held until the next finished division
//   remainder   : result, held until the next finished division
//   div_by_zero : set with done when the divisor was zero
module divider_4_restoring
  import divider_4_restoring_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] r_reg, r_n;
  logic [WIDTH-1:0] q_reg, q_n;
  logic [WIDTH-1:0] dvs_reg, dvs_n;
  logic [WIDTH-1:0] quotient_n, remainder_n;
  logic             busy_n, done_n, dbz_n;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;

  // Bring the next dividend bit into the partial remainder.
  assign r_shift = {r_reg, q_reg[WIDTH-1]};

  divider_4_restoring_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (r_shift),
    .divisor (dvs_reg),
    .rem_out (step_rem),
    .q_bit   (step_q_bit)
  );

  // Next-state and next-output logic. FIN behaves like IDLE for accepting
  // a new start, so back-to-back divisions lose no cycle. A zero divisor
  // still passes through RUN for one silent cycle (busy stays low) so the
  // result appears one clock after the start edge; that cycle uses the
  // unshifted dividend still sitting in the quotient register.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    r_n         = r_reg;
    q_n         = q_reg;
    dvs_n       = dvs_reg;
    quotient_n  = quotient;
    remainder_n = remainder;
    busy_n      = busy;
    done_n      = 1'b0;
    dbz_n       = div_by_zero;

    unique case (state)
      ST_IDLE, ST_FIN: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        if (start) begin
          state_n = ST_RUN;
          r_n     = '0;
          q_n     = dividend;
          dvs_n   = divisor;
          cnt_n   = CW'(WIDTH - 1);
          dbz_n   = 1'b0;
          busy_n  = (divisor != '0);
        end
      end

      ST_RUN: begin
        if (dvs_reg == '0) begin
          state_n     = ST_FIN;
          busy_n      = 1'b0;
          done_n      = 1'b1;
          dbz_n       = 1'b1;
          quotient_n  = '1;
          remainder_n = q_reg;
        end else begin
          r_n   = step_rem;
          q_n   = {q_reg[WIDTH-2:0], step_q_bit};
          cnt_n = cnt - 1'b1;
          if (cnt == '0) begin
            state_n     = ST_FIN;
            cnt_n       = '0;
            busy_n      = 1'b0;
            done_n      = 1'b1;
            quotient_n  = {q_reg[WIDTH-2:0], step_q_bit};
            remainder_n = step_rem;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      dvs_reg     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      r_reg       <= r_n;
      q_reg       <= q_n;
      dvs_reg     <= dvs_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      busy        <= busy_n;
      done        <= done_n;
      div_by_zero <= dbz_n;
    end
  end

endmodule
